hc4_addr_gen: RTL
=================

// Module: hc4_addr_gen
// PURPOSE
//  Registered address-generation unit for the HC4 core. It generalises the combinational address mux.
//  Supports [AB] absolute, [AB]+ post-increment, and paged register-indirect modes.
//  Drives the data-memory address and runs a req/ack handshake with bounded wait states and timeout.
//  Sits between the decoder/register file and the data-memory port.
// PARAMETERS
//  ADDR_W    8  memory address width (>= REG_AW+1)
//  REG_AW    4  register-address width (low field in register mode)
//  WAIT_MAX  3  max cycles to wait for mem_ack before timeout (1..15)
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  start      in   1                 launch access; sampled only in IDLE
//  opcode     in   4                 mode = opcode[2:0]; opcode[3] ignored
//  reg_addr   in   REG_AW            register-mode low address
//  ab_addr    in   ADDR_W            AB pointer value
//  page_we    in   1                 load page register
//  page_din   in   ADDR_W-REG_AW     page value
//  mem_ack    in   1                 memory completes access
//  addr_out   out  ADDR_W            registered memory address
//  mem_req    out  1                 access request
//  busy       out  1                 high in any state except IDLE
//  done       out  1                 1-cycle pulse, access completed
//  timeout    out  1                 1-cycle pulse, no ack within WAIT_MAX
//  ab_wr      out  1                 1-cycle pulse, write ab_next back to AB
//  ab_next    out  ADDR_W            ab_addr+1 mod 2^ADDR_W, latched
//  ab_wrap    out  1                 ab_next wrapped to 0 (valid with ab_wr)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - State goes to IDLE; every output is 0.
//   - The page register clears to 0 and the wait counter clears to 0.
//  Mode decode at launch:
//   - opcode[2:0]=000: addr = ab_addr.
//   - opcode[2:0]=111: addr = ab_addr, with post-increment.
//   - Otherwise: addr = {page, reg_addr}.
//  FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE:
//   - IDLE, start=1 at edge N: latch addr_out, mode and ab_next. At N+1, mem_req=1 and busy=1 (state REQ).
//   - REQ/WAIT, mem_ack=1 at an edge: mem_req drops next cycle and the state goes to DONE. Zero-wait access: done at N+2.
//   - REQ/WAIT, no ack: the wait counter increments. When it reaches WAIT_MAX without ack, go to DONE and pulse timeout instead of done. ab_wr is suppressed on timeout.
//   - DONE: one cycle. done=1, or timeout=1. ab_wr=1 only in post-increment mode with ack. Return to IDLE next edge.
//  mem_req stays high, and addr_out stays stable, from REQ until ack or timeout.
//  start outside IDLE is ignored; there is no queueing. start in the DONE cycle is also ignored, so back-to-back spacing is at least one IDLE cycle.
//  page_we in any state: the page updates next edge. An in-flight access keeps its latched address; the new page applies from the next launch.
//  page_we together with start in the same cycle: the launch uses the OLD page.
//  ab_next = ab_addr + 1, truncated to ADDR_W. ab_wrap = (ab_addr == all ones).
//  mem_ack in IDLE or DONE is ignored.
//  Reset mid-access: immediate return to IDLE; mem_req drops asynchronously; no done pulse.
// STRUCTURE
//  Shared package hc4_pkg:
//   - mode constants MODE_AB=3'b000, MODE_ABINC=3'b111.
//   - FSM state encoding.
//  One sub-module, hc4_addr_sel: the combinational mode/page/reg select, reusable by the fetch path.
//  The FSM, wait counter and output registers stay in this module.
// TESTING
//  1 Reset: assert rst_n=0 mid-REQ -> all outputs 0 at once; page=0; next launch uses page 0.
//  2 AB, zero wait: opcode=0000, ab=AB, ack tied high -> addr_out=AB, req 1 cycle, done at N+2, ab_wr=0.
//  3 Paged register: page_we with page_din=3, then opcode=0010, reg=A -> addr_out=3A. Same-cycle page_we=5 -> still 3A.
//  4 Post-increment wrap: opcode=0111, ab=FF, ack after 2 waits -> addr_out=FF, ab_wr=1, ab_next=00, ab_wrap=1.
//  5 Timeout: WAIT_MAX=3, ack never asserted -> req held 4 cycles, timeout=1, done=0, ab_wr=0.
//  6 Busy-start: start pulses during WAIT and DONE -> ignored; addr_out unchanged; exactly one done.

Source files
------------

// File: rtl/hc4_pkg.sv
// hc4_pkg: shared definitions for the HC4 address-generation path.
//   - Addressing-mode encodings (opcode[2:0]).
//   - FSM state encoding for the access sequencer.
package hc4_pkg;

  localparam int unsigned MODE_W = 3;

  // Modes using the AB pointer; every other encoding is paged register-indirect.
  localparam logic [MODE_W-1:0] MODE_AB    = 3'b000;
  localparam logic [MODE_W-1:0] MODE_ABINC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/hc4_addr_sel.sv
// hc4_addr_sel: combinational address select for the HC4 core.
// Ports:
//   i_mode       addressing mode (opcode[2:0])
//   i_page       page register value (high address field)
//   i_reg_addr   register-mode low address field
//   i_ab_addr    AB pointer value
//   o_addr_c     selected address (combinational)
//   o_post_inc_c mode requests AB post-increment (combinational)
module hc4_addr_sel
  import hc4_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_AW = 4
) (
  input  logic [MODE_W-1:0]        i_mode,
  input  logic [ADDR_W-REG_AW-1:0] i_page,
  input  logic [REG_AW-1:0]        i_reg_addr,
  input  logic [ADDR_W-1:0]        i_ab_addr,
  output logic [ADDR_W-1:0]        o_addr_c,
  output logic                     o_post_inc_c
);

  // Paged register-indirect is the fallback for every non-AB encoding.
  always_comb begin
    o_addr_c     = {i_page, i_reg_addr};
    o_post_inc_c = 1'b0;
    if (i_mode == MODE_AB) begin
      o_addr_c = i_ab_addr;
    end else if (i_mode == MODE_ABINC) begin
      o_addr_c     = i_ab_addr;
      o_post_inc_c = 1'b1;
    end
  end

endmodule

// File: rtl/hc4_addr_gen.sv
// hc4_addr_gen: registered address generator with req/ack memory handshake.
// Ports:
//   clk, rst_n   clock (rising edge), async active-low reset
//   start        launch an access (accepted only in IDLE)
//   opcode       opcode[2:0] selects mode; opcode[3] unused
//   reg_addr     low address field for register mode
//   ab_addr      AB pointer value
//   page_we      load page register from page_din
//   page_din     new page value
//   mem_ack      memory completes access
//   addr_out     latched memory address
//   mem_req      access request, held until ack or timeout
//   busy         sequencer not idle
//   done         1-cycle pulse, access acknowledged
//   timeout      1-cycle pulse, no ack within WAIT_MAX cycles
//   ab_wr        1-cycle pulse, write ab_next back to AB (post-inc + ack)
//   ab_next      latched ab_addr + 1
//   ab_wrap      latched ab_addr was all ones
module hc4_addr_gen
  import hc4_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned WAIT_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               opcode,
  input  logic [REG_AW-1:0]        reg_addr,
  input  logic [ADDR_W-1:0]        ab_addr,
  input  logic                     page_we,
  input  logic [ADDR_W-REG_AW-1:0] page_din,
  input  logic                     mem_ack,
  output logic [ADDR_W-1:0]        addr_out,
  output logic                     mem_req,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     ab_wr,
  output logic [ADDR_W-1:0]        ab_next,
  output logic                     ab_wrap
);

  localparam int unsigned PAGE_W = ADDR_W - REG_AW;
  localparam int unsigned CNT_W  = 4;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic [PAGE_W-1:0]   r_page;
  logic                r_post_inc;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_inc;
  logic                w_launch;
  logic                w_req_nxt, w_busy_nxt, w_done_nxt, w_timeout_nxt, w_ab_wr_nxt;
  logic                w_unused_op3;

  assign w_unused_op3 = opcode[3];

  hc4_addr_sel #(
    .ADDR_W (ADDR_W),
    .REG_AW (REG_AW)
  ) u_addr_sel (
    .i_mode       (opcode[2:0]),
    .i_page       (r_page),
    .i_reg_addr   (reg_addr),
    .i_ab_addr    (ab_addr),
    .o_addr_c     (w_sel_addr),
    .o_post_inc_c (w_sel_inc)
  );

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_launch       = 1'b0;
    w_req_nxt      = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_ab_wr_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wait_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = ST_REQ;
          w_launch    = 1'b1;
          w_req_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_REQ, ST_WAIT: begin
        w_busy_nxt = 1'b1;
        // Ack wins over an expiring wait budget on the same edge.
        if (mem_ack) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_ab_wr_nxt = r_post_inc;
        end else if (r_wait_cnt == CNT_W'(WAIT_MAX)) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
          w_req_nxt      = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Handshake/status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      ab_wr   <= 1'b0;
    end else begin
      mem_req <= w_req_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      timeout <= w_timeout_nxt;
      ab_wr   <= w_ab_wr_nxt;
    end
  end

  // Launch-time latches; a same-edge page_we only affects later launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_out   <= '0;
      ab_next    <= '0;
      ab_wrap    <= 1'b0;
      r_post_inc <= 1'b0;
    end else if (w_launch) begin
      addr_out   <= w_sel_addr;
      ab_next    <= ab_addr + ADDR_W'(1);
      ab_wrap    <= &ab_addr;
      r_post_inc <= w_sel_inc;
    end
  end

  // Page register, writable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page <= '0;
    end else if (page_we) begin
      r_page <= page_din;
    end
  end

endmodule
